// File: rtl/carry_chain_accumulator.sv
// carry_chain_accumulator: W-bit add/sub accumulator on a carry-mux ripple chain (in: CK RST CLR LOAD EN SUB D CIN; out: Q CO COUT OVF ZERO VALID)
module carry_chain_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             EN,
  input  logic             SUB,
  input  logic [WIDTH-1:0] D,
  input  logic             CIN,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             VALID
);
  logic [WIDTH-1:0] b, p, g, sum;
  logic [WIDTH:0]   c;
  assign b    = SUB ? ~D : D;
  assign p    = Q ^ b;
  assign g    = Q;
  assign c[0] = CIN;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign c[i+1] = p[i] ? c[i] : g[i];
  end
  assign sum  = p ^ c[WIDTH-1:0];
  assign CO   = c[WIDTH];
  assign ZERO = Q == '0;
  always_ff @(posedge CK) begin
    if (RST || CLR) begin
      Q     <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else if (LOAD) begin
      Q     <= D;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
      VALID <= 1'b1;
    end else if (EN) begin
      Q     <= sum;
      COUT  <= c[WIDTH];
      OVF   <= c[WIDTH] ^ c[WIDTH-1];
      VALID <= 1'b1;
    end else begin
      VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_carry_chain_accumulator.sv
// tb_carry_chain_accumulator: vector table plus cascaded 16-bit random scoreboard for carry_chain_accumulator
module tb_carry_chain_accumulator;
  logic       ck = 0;
  logic       rst, clr, load, en, sub, cin;
  logic [7:0] d_lo, d_hi;
  logic [7:0] q_lo, q_hi;
  logic       co_lo, co_hi, cout_lo, cout_hi, ovf_lo, ovf_hi, zero_lo, zero_hi, valid_lo, valid_hi;
  int         checks = 0, errors = 0;

  always #5 ck = ~ck;

  carry_chain_accumulator #(.WIDTH(8)) u_lo (
    .CK(ck), .RST(rst), .CLR(clr), .LOAD(load), .EN(en), .SUB(sub), .D(d_lo), .CIN(cin),
    .Q(q_lo), .CO(co_lo), .COUT(cout_lo), .OVF(ovf_lo), .ZERO(zero_lo), .VALID(valid_lo));
  carry_chain_accumulator #(.WIDTH(8)) u_hi (
    .CK(ck), .RST(rst), .CLR(clr), .LOAD(load), .EN(en), .SUB(sub), .D(d_hi), .CIN(co_lo),
    .Q(q_hi), .CO(co_hi), .COUT(cout_hi), .OVF(ovf_hi), .ZERO(zero_hi), .VALID(valid_hi));

  typedef struct {
    logic       rst, clr, load, en, sub, cin;
    logic [7:0] d;
    logic [7:0] q;
    logic       cout, ovf, valid, zero;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic        cout, ovf, valid;
  } exp16_t;

  vec_t   vecs[15];
  vec_t   sb8[$];
  exp16_t sb16[$];
  logic [15:0] m_q;
  logic        m_cout, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, c, l, e, s, ci, input logic [7:0] d,
                              input logic [7:0] q, input logic co, ov, v, z);
    vec_t x;
    x.rst = r; x.clr = c; x.load = l; x.en = e; x.sub = s; x.cin = ci; x.d = d;
    x.q = q; x.cout = co; x.ovf = ov; x.valid = v; x.zero = z;
    return x;
  endfunction

  task automatic cas_op(input logic r, c, l, e, s, ci, input logic [15:0] d);
    exp16_t      x, y;
    logic [15:0] b;
    logic [16:0] sm;
    @(negedge ck);
    rst = r; clr = c; load = l; en = e; sub = s; cin = ci; d_lo = d[7:0]; d_hi = d[15:8];
    b  = s ? ~d : d;
    sm = {1'b0, m_q} + {1'b0, b} + {16'd0, ci};
    if (r || c) begin
      m_q = '0; m_cout = 0; m_ovf = 0; x.valid = 0;
    end else if (l) begin
      m_q = d; m_cout = 0; m_ovf = 0; x.valid = 1;
    end else if (e) begin
      m_ovf = (m_q[15] == b[15]) && (sm[15] != m_q[15]);
      m_q = sm[15:0]; m_cout = sm[16]; x.valid = 1;
    end else begin
      x.valid = 0;
    end
    x.q = m_q; x.cout = m_cout; x.ovf = m_ovf;
    sb16.push_back(x);
    @(posedge ck);
    #1;
    y = sb16.pop_front();
    chk("cas_q", {16'd0, q_hi, q_lo}, {16'd0, y.q});
    chk("cas_cout", {31'd0, cout_hi}, {31'd0, y.cout});
    chk("cas_ovf", {31'd0, ovf_hi}, {31'd0, y.ovf});
    chk("cas_valid", {31'd0, valid_hi}, {31'd0, y.valid});
  endtask

  initial begin
    //            rst clr ld en sub cin d       q      co ov v  z
    vecs[0]  = mk(1, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 8'h20, 8'h10, 1, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 8'hAA, 8'h10, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 8'h7F, 8'h7F, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 8'h01, 8'h80, 0, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 8'h01, 8'h80, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 8'h05, 8'h05, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 1, 1, 1, 8'h03, 8'h02, 1, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 1, 8'h05, 8'hFD, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 0, 8'h3C, 8'h3C, 0, 0, 1, 0);
    vecs[12] = mk(0, 1, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 1, 0, 1, 8'hFF, 8'h00, 1, 0, 1, 1);
    vecs[14] = mk(1, 0, 0, 1, 0, 1, 8'h42, 8'h00, 0, 0, 0, 1);
    rst = 1; clr = 0; load = 0; en = 0; sub = 0; cin = 0; d_lo = 0; d_hi = 0;
    foreach (vecs[i]) begin
      vec_t e;
      @(negedge ck);
      rst = vecs[i].rst; clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
      sub = vecs[i].sub; cin = vecs[i].cin; d_lo = vecs[i].d;
      sb8.push_back(vecs[i]);
      @(posedge ck);
      #1;
      e = sb8.pop_front();
      chk($sformatf("v%0d_q", i), {24'd0, q_lo}, {24'd0, e.q});
      chk($sformatf("v%0d_cout", i), {31'd0, cout_lo}, {31'd0, e.cout});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf_lo}, {31'd0, e.ovf});
      chk($sformatf("v%0d_valid", i), {31'd0, valid_lo}, {31'd0, e.valid});
      chk($sformatf("v%0d_zero", i), {31'd0, zero_lo}, {31'd0, e.zero});
    end
    @(negedge ck);
    rst = 0; en = 0; sub = 0; d_lo = 8'hFF; cin = 1;
    #1 chk("co_add_carry", {31'd0, co_lo}, 32'd1);
    cin = 0;
    #1 chk("co_add_nocarry", {31'd0, co_lo}, 32'd0);
    sub = 1; d_lo = 8'h00; cin = 1;
    #1 chk("co_sub_noborrow", {31'd0, co_lo}, 32'd1);
    d_lo = 'x;
    @(posedge ck);
    #1;
    chk("hold_x_q", {24'd0, q_lo}, 32'd0);
    chk("hold_x_valid", {31'd0, valid_lo}, 32'd0);
    m_q = 'x; m_cout = 'x; m_ovf = 'x;
    cas_op(1, 0, 0, 0, 0, 0, 16'h0000);
    cas_op(0, 0, 1, 0, 0, 0, 16'h00FF);
    cas_op(0, 0, 0, 1, 0, 0, 16'h0001);
    chk("cas_upper", {24'd0, q_hi}, 32'h01);
    chk("cas_lower", {24'd0, q_lo}, 32'h00);
    for (int n = 0; n < 1000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cas_op(r < 2, r >= 2 && r < 5, r >= 5 && r < 20, r >= 20 && r < 85 || ($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/carry_chain_accumulator.md
Name: carry_chain_accumulator

Overview:
- Registered W-bit add/subtract accumulator built on a generate/propagate ripple carry chain.
- Each carry bit is computed in carry-mux form: c[i+1] = P[i] ? c[i] : G[i].
- Sits directly downstream of the carry multiplexers in the logic-block arithmetic path. It consumes the chain's carries, forms sums, and holds the result in flip-flops.
- Slices cascade: CO of one slice feeds CIN of the next to build wider accumulators.

Parameters:
- WIDTH, 8, accumulator/data width in bits (minimum 2).

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- CLR  input  1  synchronous clear of accumulator and flags.
- LOAD  input  1  load D into accumulator.
- EN  input  1  perform accumulate operation this cycle.
- SUB  input  1  0: Q+D+CIN; 1: Q+~D+CIN (two's-complement subtract when CIN=1).
- D  input  WIDTH  operand.
- CIN  input  1  carry-in to bit 0 of chain.
- Q  output  WIDTH  accumulator register.
- CO  output  1  combinational chain carry-out c[WIDTH] for cascading to the next slice.
- COUT  output  1  registered carry-out of last accepted accumulate.
- OVF  output  1  registered signed overflow of last accepted accumulate.
- ZERO  output  1  combinational, 1 when Q == 0.
- VALID  output  1  registered, pulses high for one cycle after each accepted LOAD or EN.

Behaviour:
- Reset: clock and reset are one clock CK and synchronous active-high RST. On RST high at a rising edge: Q=0, COUT=0, OVF=0, VALID=0. ZERO=1 follows.
- Priority per edge: RST > CLR > LOAD > EN > hold.
- CLR: Q=0, COUT=0, OVF=0, VALID=0.
- LOAD: Q=D, COUT=0, OVF=0, VALID=1.
- EN (no RST/CLR/LOAD):
  - Q = sum, COUT = c[WIDTH], OVF = c[WIDTH] xor c[WIDTH-1], VALID=1.
- Hold (no control asserted): Q, COUT and OVF hold; VALID=0.
- Chain definition:
  - B = SUB ? ~D : D.
  - P[i] = Q[i] xor B[i]; G[i] = Q[i] (carry-mux generate term).
  - c[0] = CIN; c[i+1] = P[i] ? c[i] : G[i].
  - sum[i] = P[i] xor c[i].
- Chain is purely combinational from Q, D, SUB and CIN. CO = c[WIDTH] is valid every cycle regardless of EN.
- Latency: exactly 1 cycle from accepted op to updated Q/COUT/OVF/VALID.
- Back-to-back EN on consecutive cycles: each cycle uses the Q from the previous edge; no bubbles.
- Wrap-around: sum is taken modulo 2^WIDTH. Carry out of the top bit appears only on COUT/CO; Q is not saturated.
- Subtract:
  - COUT=1 means no borrow (Q >= D unsigned, CIN=1).
  - COUT=0 means borrow.
- Simultaneous LOAD and EN: LOAD wins; no arithmetic; COUT/OVF cleared.
- CLR or RST asserted mid-sequence: takes effect at that edge. Any EN in the same cycle is discarded and VALID=0 next cycle.
- Cascading: the lower slice's CO drives the upper slice's CIN, and both slices share EN/SUB. The combined 2*WIDTH result must equal a single 2*WIDTH accumulator.
- No X propagation from D when LOAD=EN=0: state holds regardless of D.

Test Plan:
- Reset: RST=1 for 2 cycles with EN=1, D=8'hFF -> Q=0, COUT=0, OVF=0, VALID=0, ZERO=1.
- Add with carry: LOAD D=8'hF0, then EN=1, SUB=0, D=8'h20, CIN=0 -> after 1 cycle Q=8'h10, COUT=1, OVF=0, VALID=1 for one cycle.
- Signed overflow: LOAD 8'h7F, then EN, D=8'h01, CIN=0 -> Q=8'h80, OVF=1, COUT=0. Next cycle with EN=0 -> Q holds 8'h80, VALID=0.
- Subtract/borrow: LOAD 8'h05, EN, SUB=1, D=8'h03, CIN=1 -> Q=8'h02, COUT=1. Then same op with D=8'h05 -> Q=8'hFD, COUT=0, ZERO=0.
- Priority:
  - LOAD=1 and EN=1 with D=8'h3C -> Q=8'h3C, COUT=0.
  - Next cycle CLR=1 and EN=1 -> Q=0, VALID=0, ZERO=1.
- Cascade: two WIDTH=8 slices chained via CO->CIN. Load 16'h00FF, then add 16'h0001 -> upper Q=8'h01, lower Q=8'h00. Compare against a random 1000-op 16-bit reference model.
